// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding and default parameters for the vending controller
package vending_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, RETURN} vm_state_t;
    localparam int DEF_DOL_W      = 3;
    localparam int DEF_PRICE      = 3;
    localparam int DEF_MAX_COIN   = 5;
    localparam int DEF_CREDIT_W   = 4;
    localparam int DEF_STOCK_W    = 4;
    localparam int DEF_STOCK_INIT = 10;
endpackage

// File: rtl/vending_if.sv
// vending_if: coin acceptor requests and dispenser/hopper status bundle
interface vending_if
    import vending_pkg::*;
#(
    parameter int DOL_W    = DEF_DOL_W,
    parameter int CREDIT_W = DEF_CREDIT_W
);
    logic [DOL_W-1:0]    dol;
    logic                cancel;
    logic                restock;
    logic                vend;
    logic                change;
    logic                reject;
    logic                busy;
    logic                sold_out;
    logic [CREDIT_W-1:0] credit;
    modport master (output dol, cancel, restock, input vend, change, reject, busy, sold_out, credit);
    modport slave  (input dol, cancel, restock, output vend, change, reject, busy, sold_out, credit);
endinterface

// File: rtl/vm_stock_counter.sv
// vm_stock_counter: stock down-counter with reload and empty flag
module vm_stock_counter #(
    parameter int W    = 4,
    parameter int INIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam logic [W-1:0] INIT_C = W'(INIT);
    logic [W-1:0] count;
    always_ff @(posedge clk)
        count <= (reset || load) ? INIT_C : dec ? count - W'(1) : count;
    assign zero = count == '0;
endmodule

// File: rtl/vending_machine_ctrl.sv
// vending_machine_ctrl: credit accumulation, vend, change/refund payout and stock lockout
module vending_machine_ctrl
    import vending_pkg::*;
#(
    parameter int DOL_W      = DEF_DOL_W,
    parameter int PRICE      = DEF_PRICE,
    parameter int MAX_COIN   = DEF_MAX_COIN,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int STOCK_W    = DEF_STOCK_W,
    parameter int STOCK_INIT = DEF_STOCK_INIT
) (
    input logic     clk,
    input logic     reset,
    vending_if.slave bus
);
    if (PRICE < 1 || MAX_COIN > 2**DOL_W - 1 || PRICE - 1 + MAX_COIN > 2**CREDIT_W - 1
        || STOCK_INIT > 2**STOCK_W - 1) begin : g_bad_params
        $error("vending_machine_ctrl: parameter set out of range");
    end
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [DOL_W-1:0]    MAX_D   = DOL_W'(MAX_COIN);
    vm_state_t           state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n, sum;
    logic                reject_q, valid, sold_out;
    assign sum   = credit + CREDIT_W'(bus.dol);
    assign valid = bus.dol != '0 && bus.dol <= MAX_D && (state == IDLE || state == CREDIT)
                   && !sold_out && !bus.cancel;
    always_comb begin
        state_n  = state;
        credit_n = credit;
        case (state)
            IDLE, CREDIT:
                if (state == CREDIT && bus.cancel)
                    state_n = RETURN;
                else if (valid) begin
                    credit_n = sum;
                    state_n  = sum >= PRICE_C ? VEND : CREDIT;
                end
            VEND: begin
                credit_n = credit - PRICE_C;
                state_n  = credit == PRICE_C ? IDLE : RETURN;
            end
            RETURN: begin
                credit_n = credit - CREDIT_W'(1);
                state_n  = credit == CREDIT_W'(1) ? IDLE : RETURN;
            end
        endcase
    end
    // reset discards any in-flight credit, so no payout resumes afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            reject_q <= bus.dol != '0 && !valid;
        end
    end
    vm_stock_counter #(.W(STOCK_W), .INIT(STOCK_INIT)) u_stock (
        .clk  (clk),
        .reset(reset),
        .load (bus.restock),
        .dec  (state == VEND),
        .zero (sold_out)
    );
    assign bus.vend     = state == VEND;
    assign bus.change   = state == RETURN;
    assign bus.busy     = state == VEND || state == RETURN;
    assign bus.reject   = reject_q;
    assign bus.sold_out = sold_out;
    assign bus.credit   = credit;
endmodule

// File: tb/tb_vending_machine_ctrl.sv
// tb_vending_machine_ctrl: directed checks of purchase, change, refund, reject, stock and reset behaviour
module tb_vending_machine_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vending_if #(.DOL_W(3), .CREDIT_W(4)) vif ();
    vending_machine_ctrl #(.STOCK_INIT(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (vif.slave)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [2:0] d);
        vif.dol = d;
        tick();
        vif.dol = '0;
    endtask

    task automatic rs();
        vif.restock = 1'b1;
        tick();
        vif.restock = 1'b0;
    endtask

    // fields: vend change reject busy sold_out credit[3:0]
    task automatic e(input string tag, input logic v, c, r, b, so, input logic [3:0] cr);
        logic [8:0] obs, exp;
        exp = {v, c, r, b, so, cr};
        obs = {vif.vend, vif.change, vif.reject, vif.busy, vif.sold_out, vif.credit};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b (vend change reject busy sold_out credit)", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        vif.dol = '0;
        vif.cancel = 1'b0;
        vif.restock = 1'b0;
        tick();
        tick();
        e("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        e("idle", 0, 0, 0, 0, 0, 0);

        ins(1); e("s1_c1", 0, 0, 0, 0, 0, 1);
        tick(); e("s1_hold", 0, 0, 0, 0, 0, 1);
        ins(1); e("s1_c2", 0, 0, 0, 0, 0, 2);
        tick();
        ins(1); e("s1_vend", 1, 0, 0, 1, 0, 3);
        tick(); e("s1_done", 0, 0, 0, 0, 0, 0);
        rs();

        ins(2); e("s2_c2", 0, 0, 0, 0, 0, 2);
        ins(2); e("s2_vend", 1, 0, 0, 1, 0, 4);
        tick(); e("s2_chg", 0, 1, 0, 1, 0, 1);
        tick(); e("s2_done", 0, 0, 0, 0, 0, 0);
        rs();

        ins(3); e("p3_vend", 1, 0, 0, 1, 0, 3);
        ins(1); e("p3_busy_rej", 0, 0, 1, 0, 0, 0);
        tick(); e("p3_done", 0, 0, 0, 0, 0, 0);
        rs();

        ins(5); e("p5_vend", 1, 0, 0, 1, 0, 5);
        tick(); e("p5_chg1", 0, 1, 0, 1, 0, 2);
        tick(); e("p5_chg2", 0, 1, 0, 1, 0, 1);
        tick(); e("p5_done", 0, 0, 0, 0, 0, 0);
        rs();

        ins(2);
        ins(5); e("p7_vend", 1, 0, 0, 1, 0, 7);
        for (int i = 4; i >= 1; i--) begin
            tick(); e("p7_chg", 0, 1, 0, 1, 0, 4'(i));
        end
        tick(); e("p7_done", 0, 0, 0, 0, 0, 0);
        rs();

        ins(6); e("rej6", 0, 0, 1, 0, 0, 0);
        ins(7); e("rej7", 0, 0, 1, 0, 0, 0);
        tick(); e("rej_clear", 0, 0, 0, 0, 0, 0);

        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        e("idle_cancel", 0, 0, 0, 0, 0, 0);
        ins(2); e("c_c2", 0, 0, 0, 0, 0, 2);
        vif.cancel = 1'b1;
        vif.dol = 3'd1;
        tick();
        vif.cancel = 1'b0;
        vif.dol = '0;
        e("c_ref1", 0, 1, 1, 1, 0, 2);
        ins(1); e("c_ref2_rej", 0, 1, 1, 1, 0, 1);
        tick(); e("c_done", 0, 0, 0, 0, 0, 0);

        ins(3); e("so_vend1", 1, 0, 0, 1, 0, 3);
        tick(); e("so_left1", 0, 0, 0, 0, 0, 0);
        ins(3); e("so_vend2", 1, 0, 0, 1, 0, 3);
        tick(); e("so_empty", 0, 0, 0, 0, 1, 0);
        ins(1); e("so_rej1", 0, 0, 1, 0, 1, 0);
        ins(3); e("so_rej3", 0, 0, 1, 0, 1, 0);
        rs(); e("so_restock", 0, 0, 0, 0, 0, 0);
        ins(3); e("so_vend3", 1, 0, 0, 1, 0, 3);
        tick();
        ins(3); e("rw_vend", 1, 0, 0, 1, 0, 3);
        vif.restock = 1'b1;
        tick();
        vif.restock = 1'b0;
        e("rw_after", 0, 0, 0, 0, 0, 0);
        ins(3); tick(); e("rw_left1", 0, 0, 0, 0, 0, 0);
        ins(3); tick(); e("rw_empty", 0, 0, 0, 0, 1, 0);
        rs();

        ins(5); tick(); e("rst_chg", 0, 1, 0, 1, 0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e("rst_mid", 0, 0, 0, 0, 0, 0);
        tick(); e("rst_after", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vending_machine_ctrl.md
# vending_machine_ctrl

Parametrised successor to the single-price vending FSM. Accumulates dollar inserts from the coin acceptor, vends at a configurable price, and returns overpayment as a train of one-dollar `change` pulses. Adds cancel/refund, coin rejection, and stock tracking with sold-out lockout. Sits between the coin acceptor front end and the dispenser/hopper drivers.

## Interface
Parameters:
- `DOL_W`, 3: width of the `dol` insert bus.
- `PRICE`, 3: item price in dollars. Must be ≥1.
- `MAX_COIN`, 5: largest accepted insert. Must be ≤2^DOL_W−1.
- `CREDIT_W`, 4: credit register width. Must hold `PRICE−1+MAX_COIN`; elaboration error otherwise.
- `STOCK_W`, 4: stock counter width.
- `STOCK_INIT`, 10: stock count loaded at reset and on `restock`. Must be ≤2^STOCK_W−1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dol` in DOL_W: insert amount. Nonzero for one cycle means one insert event; 0 means idle.
- `cancel` in 1: refund request, level-sampled.
- `restock` in 1: reload stock to `STOCK_INIT`.
- `vend` out 1: one-cycle dispense pulse.
- `change` out 1: one pulse per returned dollar.
- `reject` out 1: one-cycle pulse when an insert is refused.
- `busy` out 1: high in VEND and RETURN.
- `sold_out` out 1: high when stock is 0.
- `credit` out CREDIT_W: current credit.

## Operation
States:
- IDLE: credit = 0.
- CREDIT: 0 < credit < PRICE.
- VEND: lasts exactly one cycle.
- RETURN: pays out change or a refund.

Insert acceptance. An insert is valid when all of the following hold: `1 ≤ dol ≤ MAX_COIN`, state is IDLE or CREDIT, `!sold_out`, and `!cancel`. Otherwise a nonzero `dol` asserts `reject` on the next cycle and leaves credit unchanged.

Transitions:
- IDLE/CREDIT with a valid insert: sum = credit + dol.
  - If sum ≥ PRICE, go to VEND.
  - Otherwise go to CREDIT.
  - In both cases credit ← sum.
- CREDIT with `cancel`: go to RETURN and keep credit. Cancel wins over a same-cycle insert, which is rejected.
- IDLE with `cancel`: no effect.
- VEND:
  - credit ← credit − PRICE and stock ← stock − 1.
  - Go to RETURN if the remainder is greater than 0, else go to IDLE.
- RETURN: credit ← credit − 1 each cycle. Go to IDLE when credit reaches 0. `cancel` is ignored.

Outputs and counters:
- `vend` and `change` are Moore outputs: `vend` = (state==VEND), `change` = (state==RETURN).
- `restock` takes effect in any state. If it coincides with the stock decrement in VEND, `restock` wins.
- Stock never wraps below 0, because VEND is unreachable while sold out.
- Credit arithmetic is unsigned and never exceeds `PRICE−1+MAX_COIN`.

Reset values: state=IDLE, credit=0, stock=STOCK_INIT. `vend`, `change`, `reject` and `busy` are 0. `sold_out` = (STOCK_INIT==0). Reset mid-VEND or mid-RETURN abandons the transaction: no further pulses, and credit is lost.

## Timing
- Insert sampled at edge k. From edge k, `credit` shows the sum and the state is updated.
- Completing insert at edge k:
  - `vend` is high from edge k to edge k+1.
  - `change` pulses occupy cycles k+1 … k+R, where R = sum − PRICE.
  - `busy` falls at edge k+R+1.
- Cancel at edge k with credit C: `change` is high for C consecutive cycles starting at edge k. No `vend`.
- `reject` is registered and high for exactly the one cycle after the offending insert.
- `sold_out` updates one cycle after the vend that empties stock.
- Inserts arriving during `busy` are rejected. There is no queuing.

## Structure
- Package `vending_pkg` holds:
  - the state enum `vm_state_t` {IDLE, CREDIT, VEND, RETURN}, 2-bit encoding;
  - the default parameter constants.
- Sub-module `vm_stock_counter`: a down-counter with load (`restock`), decrement enable (from VEND), and a `zero` flag that drives `sold_out`.
- The FSM, credit register and output registers live in `vending_machine_ctrl`.

## Test plan
All scenarios use default parameters (PRICE=3, MAX_COIN=5).
- $1, $1, $1 with idle cycles between → credit 1, 2, 3; one `vend` pulse; zero `change` pulses; `credit` returns to 0.
- $2 then $2 → `vend`, then exactly 1 `change` pulse; $3 alone → `vend`, 0 `change`; $5 alone → `vend`, then 2 consecutive `change` pulses; `busy` spans the vend and change cycles.
- $6 and $7 in IDLE → `reject` pulse each time; `credit` stays 0; no `vend`.
- $2 then `cancel` → 2 `change` pulses, no `vend`, IDLE afterward. A $1 insert during RETURN → `reject`, refund count unchanged.
- STOCK_INIT=2, two $3 purchases → `sold_out` = 1; next $1 → `reject`; `restock` → `sold_out` = 0 and a $3 purchase vends.
- $5 insert, `reset` asserted on the first `change` cycle → all outputs at reset values the next cycle; no further `change` pulses.
